// File: rtl/lvds_pkg.sv
// Shared LVDS I/Q link definitions: sync patterns, frame geometry and the
// IDLE/PRIME/RUN state encoding used by both the TX and RX sides.
package lvds_pkg;

    localparam logic [1:0]  I_SYNC     = 2'b10;
    localparam logic [1:0]  Q_SYNC     = 2'b01;
    localparam int          FRAME_BITS = 32;
    localparam logic [31:0] ZERO_FRAME = 32'h8000_4000;

    typedef enum logic [1:0] {
        LVDS_IDLE  = 2'd0,
        LVDS_PRIME = 2'd1,
        LVDS_RUN   = 2'd2
    } lvds_state_e;

endpackage

// File: rtl/lvds_tx_fmt.sv
// Combinational frame formatter: replaces the top two bits of each 16-bit
// half of a FIFO word with the I and Q sync patterns.
module lvds_tx_fmt
    import lvds_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] frame
);

    // Sync insertion; w[31:30] and w[15:14] are discarded
    always_comb begin
        frame = {I_SYNC, word[29:16], Q_SYNC, word[13:0]};
    end

endmodule

// File: rtl/lvds_tx.sv
// LVDS I/Q transmit serializer: pulls FIFO words and shifts formatted frames
// out two bits per clock. Optional macro: LVDS_TX_UNDERFLOW_CNT_EN.
module lvds_tx
    import lvds_pkg::*;
(
    input  logic        i_ddr_clk,
    input  logic        i_rst_b,
    input  logic        i_tx_en,
    input  logic        i_fifo_empty,
    input  logic [31:0] i_fifo_pulled_data,
    output logic        o_fifo_pull,
    output logic [1:0]  o_ddr_data,
    output logic        o_busy,
    output logic        o_frame_start
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]  o_underflow_cnt
`endif
);

    lvds_state_e            state_r, state_s;
    logic [FRAME_BITS-1:0]  shreg_r, shreg_s;
    logic [3:0]             cnt_r, cnt_s;
    logic                   pulled_r, pulled_s;
    logic                   live_r;
    logic                   pull_s;
    logic [FRAME_BITS-1:0]  fmt_frame_s;
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
    logic [7:0]             uf_cnt_r, uf_cnt_s;
`endif

    lvds_tx_fmt u_fmt (
        .word  (i_fifo_pulled_data),
        .frame (fmt_frame_s)
    );

    // Holds the pull strobe low while reset is applied and for the first clock after
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            live_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
        end
    end

    // Pull decode: only in IDLE or at cnt==14 of a running frame
    always_comb begin
        pull_s = 1'b0;
        if (live_r && i_tx_en && !i_fifo_empty) begin
            if (state_r == LVDS_IDLE) begin
                pull_s = 1'b1;
            end else if ((state_r == LVDS_RUN) && (cnt_r == 4'd14)) begin
                pull_s = 1'b1;
            end else begin
                pull_s = 1'b0;
            end
        end else begin
            pull_s = 1'b0;
        end
    end

    // Next-state logic for the framer FSM and its datapath
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        pulled_s = pulled_r;
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
        uf_cnt_s = uf_cnt_r;
`endif
        case (state_r)
            LVDS_IDLE: begin
                cnt_s    = 4'd0;
                pulled_s = 1'b0;
                if (pull_s) begin
                    state_s = LVDS_PRIME;
                end else begin
                    state_s = LVDS_IDLE;
                end
            end
            LVDS_PRIME: begin
                shreg_s = fmt_frame_s;
                cnt_s   = 4'd0;
                state_s = LVDS_RUN;
            end
            LVDS_RUN: begin
                if (cnt_r == 4'd15) begin
                    cnt_s    = 4'd0;
                    pulled_s = 1'b0;
                    if (pulled_r) begin
                        shreg_s = fmt_frame_s;
                    end else if (i_tx_en) begin
                        // Underflow: keep the link framed with an all-zero sample
                        shreg_s = ZERO_FRAME;
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
                        if (uf_cnt_r != 8'hFF) begin
                            uf_cnt_s = uf_cnt_r + 8'd1;
                        end else begin
                            uf_cnt_s = uf_cnt_r;
                        end
`endif
                    end else begin
                        shreg_s = {FRAME_BITS{1'b0}};
                        state_s = LVDS_IDLE;
                    end
                end else begin
                    shreg_s = {shreg_r[FRAME_BITS-3:0], 2'b00};
                    cnt_s   = cnt_r + 4'd1;
                    if (cnt_r == 4'd14) begin
                        pulled_s = pull_s;
                    end else begin
                        pulled_s = pulled_r;
                    end
                end
            end
            default: begin
                state_s  = LVDS_IDLE;
                shreg_s  = {FRAME_BITS{1'b0}};
                cnt_s    = 4'd0;
                pulled_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_r  <= LVDS_IDLE;
            shreg_r  <= {FRAME_BITS{1'b0}};
            cnt_r    <= 4'd0;
            pulled_r <= 1'b0;
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
            uf_cnt_r <= 8'd0;
`endif
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            cnt_r    <= cnt_s;
            pulled_r <= pulled_s;
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
            uf_cnt_r <= uf_cnt_s;
`endif
        end
    end

    // Output decode from registered state only (pull also uses the FIFO flag)
    always_comb begin
        o_fifo_pull   = pull_s;
        o_busy        = (state_r == LVDS_PRIME) || (state_r == LVDS_RUN);
        o_frame_start = (state_r == LVDS_RUN) && (cnt_r == 4'd0);
        if (state_r == LVDS_RUN) begin
            o_ddr_data = shreg_r[FRAME_BITS-1:FRAME_BITS-2];
        end else begin
            o_ddr_data = 2'b00;
        end
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
        o_underflow_cnt = uf_cnt_r;
`endif
    end

endmodule

// File: tb/tb_lvds_tx.sv
// Directed scoreboard bench for lvds_tx: a FIFO model feeds words, expected
// frames are queued as stimulus is issued and checked pair by pair.
module tb_lvds_tx;

    logic        clk = 1'b0;
    logic        i_rst_b;
    logic        i_tx_en;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_pulled_data = 32'd0;
    logic        o_fifo_pull;
    logic [1:0]  o_ddr_data;
    logic        o_busy;
    logic        o_frame_start;
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
    logic [7:0]  o_underflow_cnt;
`endif

    logic [31:0] fifo_mem [0:63];
    int          pushed_n = 0;
    int          popped_n = 0;
    logic [31:0] exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;

    lvds_tx dut (
        .i_ddr_clk          (clk),
        .i_rst_b            (i_rst_b),
        .i_tx_en            (i_tx_en),
        .i_fifo_empty       (i_fifo_empty),
        .i_fifo_pulled_data (i_fifo_pulled_data),
        .o_fifo_pull        (o_fifo_pull),
        .o_ddr_data         (o_ddr_data),
        .o_busy             (o_busy),
        .o_frame_start      (o_frame_start)
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
        ,
        .o_underflow_cnt    (o_underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign i_fifo_empty = (pushed_n == popped_n);

    // FIFO model: read data valid the cycle after a pull
    always @(posedge clk) begin
        if (o_fifo_pull) begin
            i_fifo_pulled_data <= fifo_mem[popped_n % 64];
            popped_n <= popped_n + 1;
        end
    end

    function automatic logic [31:0] frame_of(input logic [31:0] w);
        return {2'b10, w[29:16], 2'b01, w[13:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[pushed_n % 64] = w;
        pushed_n++;
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_ddr"}, {30'd0, o_ddr_data}, 32'd0);
            chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
            chk({tag, "_pull"}, {31'd0, o_fifo_pull}, 32'd0);
        end
    endtask

    // Waits up to max_wait negedges for a frame start, then checks 16 pairs
    task automatic check_frame(input string tag, input logic exp_pull, input int max_wait,
                               input int drop_at, input int rst_at);
        logic        found;
        logic [31:0] exp;
        found = 1'b0;
        for (int w = 0; w < max_wait; w++) begin
            @(negedge clk);
            if (o_frame_start) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_start_seen"}, {31'd0, found}, 32'd1);
        if (!found) return;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s_scoreboard: observed empty expected a queued frame", tag);
            return;
        end
        exp = exp_q.pop_front();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            chk({tag, "_pair"}, {30'd0, o_ddr_data}, {30'd0, exp[31-2*k -: 2]});
            chk({tag, "_fstart"}, {31'd0, o_frame_start}, {31'd0, (k == 0)});
            chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
            chk({tag, "_pull"}, {31'd0, o_fifo_pull}, {31'd0, (k == 14) ? exp_pull : 1'b0});
            if (k == drop_at) i_tx_en = 1'b0;
            if (k == rst_at) begin
                #1 i_rst_b = 1'b0;
                #1;
                chk({tag, "_rst_ddr"}, {30'd0, o_ddr_data}, 32'd0);
                chk({tag, "_rst_busy"}, {31'd0, o_busy}, 32'd0);
                chk({tag, "_rst_pull"}, {31'd0, o_fifo_pull}, 32'd0);
                chk({tag, "_rst_fstart"}, {31'd0, o_frame_start}, 32'd0);
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
                chk({tag, "_rst_ufcnt"}, {24'd0, o_underflow_cnt}, 32'd0);
`endif
                return;
            end
        end
    endtask

    initial begin
        i_rst_b = 1'b0;
        i_tx_en = 1'b0;
        #1;
        chk("reset_ddr", {30'd0, o_ddr_data}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_fstart", {31'd0, o_frame_start}, 32'd0);
        repeat (2) @(negedge clk);
        i_rst_b = 1'b1;
        idle_chk("idle_after_rst", 3);

        // Single frame: pull in IDLE, PRIME, then frame two cycles after enable
        push_word(32'h3FFF_BFFF);
        exp_q.push_back(32'hBFFF_7FFF);
        i_tx_en = 1'b1;
        #1;
        chk("first_pull", {31'd0, o_fifo_pull}, 32'd1);
        chk("first_busy_idle", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        chk("prime_busy", {31'd0, o_busy}, 32'd1);
        chk("prime_ddr", {30'd0, o_ddr_data}, 32'd0);
        chk("prime_pull", {31'd0, o_fifo_pull}, 32'd0);
        chk("prime_fstart", {31'd0, o_frame_start}, 32'd0);
        check_frame("single", 1'b0, 1, -1, -1);

        // FIFO now empty with enable held: gapless zero frames, saturating count
        for (int i = 1; i <= 300; i++) begin
            exp_q.push_back(32'h8000_4000);
            check_frame("underflow", 1'b0, 1, (i == 300) ? 5 : -1, -1);
`ifdef LVDS_TX_UNDERFLOW_CNT_EN
            chk("uf_cnt", {24'd0, o_underflow_cnt}, (i > 255) ? 32'd255 : i);
`endif
        end
        idle_chk("idle_after_drop", 2);
        push_word(32'hA5A5_5A5A);
        idle_chk("no_pull_disabled", 5);

        // Three queued words: back-to-back frames, pulls at cnt 14 of frames 1 and 2
        push_word(32'h1234_5678);
        push_word(32'hC3C3_F00F);
        exp_q.push_back(frame_of(32'hA5A5_5A5A));
        exp_q.push_back(frame_of(32'h1234_5678));
        exp_q.push_back(frame_of(32'hC3C3_F00F));
        i_tx_en = 1'b1;
        check_frame("b2b1", 1'b1, 2, -1, -1);
        check_frame("b2b2", 1'b1, 1, -1, -1);
        check_frame("b2b3", 1'b0, 1, 5, -1);
        idle_chk("idle_after_b2b", 3);

        // Reset mid-frame, then restart from a fresh sync pair
        push_word(32'h0F0F_F0F0);
        push_word(32'h5A5A_A5A5);
        exp_q.push_back(frame_of(32'h0F0F_F0F0));
        i_tx_en = 1'b1;
        check_frame("rst_frame", 1'b0, 2, -1, 9);
        @(negedge clk);
        i_rst_b = 1'b1;
        exp_q.push_back(frame_of(32'h5A5A_A5A5));
        check_frame("restart", 1'b0, 3, 5, -1);
        idle_chk("final_idle", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
